// File: rtl/chan_pkg.sv
// Shared definitions for the interposer channel arbiter: request/control word layout,
// control encodings and FSM state encoding.
package chan_pkg;

    localparam int unsigned REQ_W         = 4;
    localparam int unsigned CTRL_W        = 3;
    localparam int unsigned REQ_VALID_BIT = 3;
    localparam int unsigned REQ_DST_MSB   = 2;
    localparam int unsigned IDX_W         = 3;
    localparam int unsigned CNT_W         = 4;

    localparam logic [CTRL_W-1:0] CTRL_SEND = 3'b100;
    localparam logic [CTRL_W-1:0] CTRL_RECV = 3'b010;
    localparam logic [CTRL_W-1:0] CTRL_BYP  = 3'b001;
    localparam logic [CTRL_W-1:0] CTRL_IDLE = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set bit of eligible at or after rr_ptr,
// searching upward and wrapping from NUM_NODES-1 to 0.
module rr_picker
    import chan_pkg::*;
#(
    parameter int unsigned NUM_NODES = 8
) (
    input  logic [NUM_NODES-1:0] eligible,
    input  logic [IDX_W-1:0]     rr_ptr,
    output logic                 found,
    output logic [IDX_W-1:0]     winner
);

    // Scan farthest-first so the nearest eligible index overwrites the rest.
    always_comb begin
        int unsigned      idx;
        logic [IDX_W-1:0] idx_s;
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        idx_s  = '0;
        for (int unsigned off = NUM_NODES; off > 0; off--) begin
            idx = 32'(rr_ptr) + off - 1;
            if (idx >= NUM_NODES) begin
                idx = idx - NUM_NODES;
            end
            idx_s = IDX_W'(idx);
            if (eligible[idx_s]) begin
                found  = 1'b1;
                winner = idx_s;
            end
        end
    end

endmodule

// File: rtl/channel_arbiter.sv
// Central arbiter for one direction of the interposer channel: legality decode,
// round-robin grant, hold counter and per-node send/recv/bypass control words.
module channel_arbiter
    import chan_pkg::*;
#(
    parameter int unsigned NUM_NODES   = 8,
    parameter int unsigned DIR         = 0,
    parameter int unsigned XFER_CYCLES = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REQ_W*NUM_NODES-1:0]    request_in,
    output logic [CTRL_W*NUM_NODES-1:0]   control_out,
    output logic                          busy,
    output logic                          err_pulse,
    output logic [IDX_W-1:0]              err_node
);

    localparam logic [IDX_W:0]   NODES_W  = (IDX_W+1)'(NUM_NODES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

    logic [NUM_NODES-1:0]        legal;
    logic [NUM_NODES-1:0]        illegal;
    logic [IDX_W-1:0]            dst_arr [NUM_NODES];
    logic                        found;
    logic                        any_illegal;
    logic [IDX_W-1:0]            err_idx;
    logic [IDX_W-1:0]            win_src;
    logic [IDX_W-1:0]            win_dst;
    logic [IDX_W-1:0]            span_lo;
    logic [IDX_W-1:0]            span_hi;
    logic [IDX_W-1:0]            next_ptr;
    logic [CTRL_W*NUM_NODES-1:0] ctrl_next;

    state_t                      state;
    logic [IDX_W-1:0]            rr_ptr;
    logic [CNT_W-1:0]            hold_cnt;

    assign win_dst  = dst_arr[win_src];
    assign span_lo  = (win_src < win_dst) ? win_src : win_dst;
    assign span_hi  = (win_src < win_dst) ? win_dst : win_src;
    assign next_ptr = (win_src == LAST_IDX) ? '0 : win_src + 1'b1;

    // Per-node legality and the control word this node would get if win_src were granted.
    for (genvar g = 0; g < NUM_NODES; g++) begin : g_node
        logic             vld;
        logic [IDX_W-1:0] dst;
        logic             dir_ok;

        assign vld        = request_in[REQ_W*g + REQ_VALID_BIT];
        assign dst        = request_in[REQ_W*g + REQ_DST_MSB -: IDX_W];
        assign dir_ok     = (DIR != 0) ? (dst < IDX_W'(g)) : (dst > IDX_W'(g));
        assign legal[g]   = vld && ({1'b0, dst} < NODES_W) && (dst != IDX_W'(g)) && dir_ok;
        assign illegal[g] = vld && !legal[g];
        assign dst_arr[g] = dst;

        assign ctrl_next[CTRL_W*g +: CTRL_W] =
            (IDX_W'(g) == win_src)                             ? CTRL_SEND :
            (IDX_W'(g) == win_dst)                             ? CTRL_RECV :
            ((IDX_W'(g) > span_lo) && (IDX_W'(g) < span_hi))   ? CTRL_BYP  :
                                                                 CTRL_IDLE;
    end

    rr_picker #(.NUM_NODES(NUM_NODES)) u_grant (
        .eligible (legal),
        .rr_ptr   (rr_ptr),
        .found    (found),
        .winner   (win_src)
    );

    // Lowest illegal requester: a round-robin search anchored at index 0.
    rr_picker #(.NUM_NODES(NUM_NODES)) u_err (
        .eligible (illegal),
        .rr_ptr   ('0),
        .found    (any_illegal),
        .winner   (err_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            control_out <= '0;
            busy        <= 1'b0;
            err_pulse   <= 1'b0;
            err_node    <= '0;
            rr_ptr      <= '0;
            hold_cnt    <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    err_pulse <= any_illegal;
                    if (any_illegal) begin
                        err_node <= err_idx;
                    end
                    if (found) begin
                        state       <= ST_XFER;
                        control_out <= ctrl_next;
                        busy        <= 1'b1;
                        hold_cnt    <= CNT_W'(XFER_CYCLES - 1);
                        rr_ptr      <= next_ptr;
                    end
                end
                ST_XFER: begin
                    if (hold_cnt == '0) begin
                        state       <= ST_GAP;
                        control_out <= '0;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    control_out <= '0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_channel_arbiter.sv
// Bench for channel_arbiter: directed scenarios on three configurations plus
// randomized requests checked against a slot-level reference model.
module tb_channel_arbiter;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] req   [3];
    logic [23:0] ctrl  [3];
    logic        busy  [3];
    logic        errp  [3];
    logic [2:0]  errn  [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    channel_arbiter #(.NUM_NODES(8), .DIR(0), .XFER_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .request_in(req[0]), .control_out(ctrl[0]),
        .busy(busy[0]), .err_pulse(errp[0]), .err_node(errn[0]));

    channel_arbiter #(.NUM_NODES(8), .DIR(0), .XFER_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .request_in(req[1]), .control_out(ctrl[1]),
        .busy(busy[1]), .err_pulse(errp[1]), .err_node(errn[1]));

    channel_arbiter #(.NUM_NODES(8), .DIR(1), .XFER_CYCLES(1)) dut_c (
        .clk(clk), .reset(reset), .request_in(req[2]), .control_out(ctrl[2]),
        .busy(busy[2]), .err_pulse(errp[2]), .err_node(errn[2]));

    // Reference model: each instance is either free or owes a number of busy slots.
    int          m_dir  [3] = '{0, 0, 1};
    int          m_xfer [3] = '{1, 3, 1};
    int          m_left [3] = '{0, 0, 0};
    int          m_ptr  [3] = '{0, 0, 0};
    logic [23:0] m_pat  [3] = '{24'h0, 24'h0, 24'h0};
    logic        m_errp [3] = '{1'b0, 1'b0, 1'b0};
    logic [2:0]  m_errn [3] = '{3'd0, 3'd0, 3'd0};

    logic [31:0] mtmp;
    logic        mv;
    int          md, msrc, mdst, midx;
    bit          mfound;
    bit          mleg [8];
    logic [2:0]  mcode;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int m = 0; m < 3; m++) begin
                m_left[m] = 0; m_ptr[m] = 0; m_pat[m] = '0;
                m_errp[m] = 1'b0; m_errn[m] = '0;
            end
        end else begin
            for (int m = 0; m < 3; m++) begin
                if (m_left[m] == 0) begin
                    m_errp[m] = 1'b0;
                    for (int n = 0; n < 8; n++) begin
                        mtmp = req[m] >> (4 * n);
                        mv = mtmp[3];
                        md = int'(mtmp[2:0]);
                        mleg[n] = mv && (md != n) && ((m_dir[m] == 1) ? (md < n) : (md > n));
                        if (mv && !mleg[n] && !m_errp[m]) begin
                            m_errp[m] = 1'b1;
                            m_errn[m] = 3'(n);
                        end
                    end
                    mfound = 0; msrc = 0;
                    for (int k = 0; k < 8; k++) begin
                        midx = (m_ptr[m] + k) % 8;
                        if (!mfound && mleg[midx]) begin
                            mfound = 1; msrc = midx;
                        end
                    end
                    if (mfound) begin
                        mtmp = req[m] >> (4 * msrc);
                        mdst = int'(mtmp[2:0]);
                        m_pat[m] = '0;
                        for (int n = 0; n < 8; n++) begin
                            if (n == msrc)      mcode = 3'b100;
                            else if (n == mdst) mcode = 3'b010;
                            else if ((n > msrc && n < mdst) || (n < msrc && n > mdst)) mcode = 3'b001;
                            else                mcode = 3'b000;
                            m_pat[m] = m_pat[m] | (24'(mcode) << (3 * n));
                        end
                        m_left[m] = m_xfer[m] + 1;
                        m_ptr[m]  = (msrc + 1) % 8;
                    end
                end else begin
                    m_errp[m] = 1'b0;
                    m_left[m] = m_left[m] - 1;
                end
            end
        end
    end

    function automatic logic [31:0] rq(input int node, input int dst);
        logic [3:0] w;
        w = 4'b1000 | 4'(dst);
        return 32'(w) << (4 * node);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (ctrl[m] !== 24'h0 || busy[m] !== 1'b0 || errp[m] !== 1'b0 || errn[m] !== 3'd0) begin
                errors++;
                $display("FAIL reset dut%0d: ctrl=%h busy=%b errp=%b errn=%0d want all zero",
                         m, ctrl[m], busy[m], errp[m], errn[m]);
            end
        end
    endtask

    task automatic test_single();
        logic [23:0] exp;
        exp = {3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        req[0] = rq(4, 6);
        step();
        req[0] = '0;
        checks++;
        if (ctrl[0] !== exp || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_xfer: ctrl=%h busy=%b want ctrl=%h busy=1", ctrl[0], busy[0], exp);
        end
        step();
        checks++;
        if (ctrl[0] !== 24'h0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_gap: ctrl=%h busy=%b want ctrl=0 busy=1", ctrl[0], busy[0]);
        end
        step();
        checks++;
        if (ctrl[0] !== 24'h0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: ctrl=%h busy=%b want ctrl=0 busy=0", ctrl[0], busy[0]);
        end
    endtask

    task automatic test_round_robin();
        logic [23:0] exp1, exp4, exp6;
        exp1 = {3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b100, 3'b000};
        exp4 = {3'b010, 3'b001, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        exp6 = {3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        req[0] = rq(1, 3) | rq(4, 7);
        step();
        checks++;
        if (ctrl[0] !== exp1) begin
            errors++;
            $display("FAIL rr_first: ctrl=%h want %h", ctrl[0], exp1);
        end
        step();
        step();
        checks++;
        if (ctrl[0] !== 24'h0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL rr_gap_idle: ctrl=%h busy=%b want 0/0", ctrl[0], busy[0]);
        end
        step();
        req[0] = '0;
        checks++;
        if (ctrl[0] !== exp4) begin
            errors++;
            $display("FAIL rr_second: ctrl=%h want %h", ctrl[0], exp4);
        end
        step();
        step();
        // Pointer now sits at 5, so node 6 beats node 3.
        req[0] = rq(3, 4) | rq(6, 7);
        step();
        req[0] = '0;
        checks++;
        if (ctrl[0] !== exp6) begin
            errors++;
            $display("FAIL rr_ptr_after: ctrl=%h want %h", ctrl[0], exp6);
        end
        step();
        step();
    endtask

    task automatic test_illegal();
        req[0] = rq(6, 2);
        step();
        req[0] = '0;
        checks++;
        if (errp[0] !== 1'b1 || errn[0] !== 3'd6 || ctrl[0] !== 24'h0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL illegal_dir: errp=%b errn=%0d ctrl=%h busy=%b want 1/6/0/0",
                     errp[0], errn[0], ctrl[0], busy[0]);
        end
        step();
        checks++;
        if (errp[0] !== 1'b0 || errn[0] !== 3'd6) begin
            errors++;
            $display("FAIL illegal_pulse_end: errp=%b errn=%0d want 0/6", errp[0], errn[0]);
        end
    endtask

    task automatic test_wrap();
        logic [23:0] exp;
        exp = {3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100};
        req[0] = rq(7, 7) | rq(0, 1);
        step();
        req[0] = '0;
        checks++;
        if (ctrl[0] !== exp || errp[0] !== 1'b1 || errn[0] !== 3'd7) begin
            errors++;
            $display("FAIL wrap_grant: ctrl=%h errp=%b errn=%0d want %h/1/7",
                     ctrl[0], errp[0], errn[0], exp);
        end
        step();
        step();
    endtask

    task automatic test_long_hold();
        logic [23:0] exp_a, exp_b;
        exp_a = {3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b100, 3'b000, 3'b000};
        exp_b = {3'b000, 3'b000, 3'b000, 3'b000, 3'b010, 3'b001, 3'b001, 3'b100};
        req[1] = rq(2, 5);
        step();
        req[1] = '0;
        checks++;
        if (ctrl[1] !== exp_a) begin
            errors++;
            $display("FAIL hold_c1: ctrl=%h want %h", ctrl[1], exp_a);
        end
        step();
        checks++;
        if (ctrl[1] !== exp_a) begin
            errors++;
            $display("FAIL hold_c2: ctrl=%h want %h", ctrl[1], exp_a);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if (ctrl[1] !== 24'h0 || busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: ctrl=%h busy=%b want 0/0", ctrl[1], busy[1]);
        end
        step();
        reset = 1'b1;
        req[1] = rq(0, 3);
        step();
        req[1] = '0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (ctrl[1] !== exp_b || busy[1] !== 1'b1) begin
                errors++;
                $display("FAIL hold_after_reset c%0d: ctrl=%h busy=%b want %h/1", c, ctrl[1], busy[1], exp_b);
            end
            step();
        end
        checks++;
        if (ctrl[1] !== 24'h0 || busy[1] !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: ctrl=%h busy=%b want 0/1", ctrl[1], busy[1]);
        end
        step();
        checks++;
        if (busy[1] !== 1'b0) begin
            errors++;
            $display("FAIL hold_idle: busy=%b want 0", busy[1]);
        end
    endtask

    task automatic test_dir1();
        logic [23:0] exp;
        exp = {3'b000, 3'b000, 3'b100, 3'b001, 3'b001, 3'b010, 3'b000, 3'b000};
        req[2] = rq(5, 2);
        step();
        req[2] = '0;
        checks++;
        if (ctrl[2] !== exp || errp[2] !== 1'b0) begin
            errors++;
            $display("FAIL dir1_grant: ctrl=%h errp=%b want %h/0", ctrl[2], errp[2], exp);
        end
        step();
        step();
    endtask

    task automatic test_random();
        logic [23:0] exp;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int m = 0; m < 3; m++) begin
                req[m] = '0;
                for (int n = 0; n < 8; n++) begin
                    if ($urandom_range(0, 7) < 3) begin
                        req[m] = req[m] | rq(n, int'($urandom_range(0, 7)));
                    end
                end
            end
            step();
            for (int m = 0; m < 3; m++) begin
                exp = (m_left[m] > 1) ? m_pat[m] : 24'h0;
                checks++;
                if (ctrl[m] !== exp) begin
                    errors++;
                    $display("FAIL rand_ctrl dut%0d cyc%0d: got %h want %h", m, cyc, ctrl[m], exp);
                end
                checks++;
                if (busy[m] !== (m_left[m] > 0)) begin
                    errors++;
                    $display("FAIL rand_busy dut%0d cyc%0d: got %b want %b", m, cyc, busy[m], m_left[m] > 0);
                end
                checks++;
                if (errp[m] !== m_errp[m] || errn[m] !== m_errn[m]) begin
                    errors++;
                    $display("FAIL rand_err dut%0d cyc%0d: got %b/%0d want %b/%0d",
                             m, cyc, errp[m], errn[m], m_errp[m], m_errn[m]);
                end
            end
        end
    endtask

    initial begin
        for (int m = 0; m < 3; m++) req[m] = '0;
        #12;
        test_reset();
        reset = 1'b1;
        test_single();
        test_round_robin();
        test_illegal();
        test_wrap();
        test_long_hold();
        test_dir1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
